// File: rtl/vram_display_fetch_pkg.sv
// Shared definitions for the VRAM display fetch engine: bus widths, FSM
// state encoding and the row address helper.
package vram_display_fetch_pkg;

    localparam int VRAM_ADDR_W = 20;
    localparam int TUPLE_W     = 24;
    localparam int COLUMN_W    = 9;
    localparam int CNT_W       = 10;   // holds 0..512 request/return counts
    localparam int CREDIT_W    = 4;    // holds 0..15 outstanding reads

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Address of tuple idx within the row; wraps modulo 2^VRAM_ADDR_W.
    function automatic logic [VRAM_ADDR_W-1:0] row_addr(
        input logic [VRAM_ADDR_W-1:0] base,
        input logic [CNT_W-1:0]       idx
    );
        return base + {{(VRAM_ADDR_W-CNT_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/vram_display_fetch_if.sv
// VRAM arbiter read port: request/address/ack plus in-order read returns.
// The fetch engine uses the master view, the arbiter the slave view.
interface vram_display_fetch_if;
    import vram_display_fetch_pkg::*;

    logic                   vram_req;
    logic [VRAM_ADDR_W-1:0] vram_address;
    logic                   vram_ack;
    logic [TUPLE_W-1:0]     vram_rdata;
    logic                   vram_rdata_valid;

    modport master (
        output vram_req, vram_address,
        input  vram_ack, vram_rdata, vram_rdata_valid
    );

    modport slave (
        input  vram_req, vram_address,
        output vram_ack, vram_rdata, vram_rdata_valid
    );

endinterface

// File: rtl/vram_display_fetch_credit.sv
// Outstanding-read counter. Counts accepted reads minus returned reads and
// reports whether another request may be raised given this cycle's traffic.
module vram_display_fetch_credit
    import vram_display_fetch_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_inc,
    input  logic                i_dec,
    input  logic [CREDIT_W-1:0] i_limit,
    output logic                o_can_issue,
    output logic                o_empty
);

    logic [CREDIT_W-1:0] r_cnt;
    logic [CREDIT_W-1:0] w_cnt_next;

    // Next outstanding count; accept and return in the same cycle cancel.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_inc && !i_dec) begin
            w_cnt_next = r_cnt + {{(CREDIT_W-1){1'b0}}, 1'b1};
        end else if (!i_inc && i_dec) begin
            w_cnt_next = r_cnt - {{(CREDIT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    assign o_can_issue = (w_cnt_next < i_limit);
    assign o_empty     = (r_cnt == {CREDIT_W{1'b0}});

    // Outstanding counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {CREDIT_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/vram_display_fetch.sv
// Row fetch engine: on a start strobe reads ROW_WORDS consecutive tuples from
// VRAM (pipelined, at most MAX_OUTSTANDING in flight) and streams them back as
// column/data/valid writes for the row buffer.
// Optional feature: define DISPLAY_FETCH_STATS_EN to add row/stall counters.
module vram_display_fetch
    import vram_display_fetch_pkg::*;
#(
    parameter int ROW_WORDS       = 400,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   i_master_clk,
    input  logic                   i_reset,
    input  logic [VRAM_ADDR_W-1:0] i_display_address,
    input  logic                   i_display_start,
    vram_display_fetch_if.master   vram_bus,
    output logic [COLUMN_W-1:0]    o_display_column,
    output logic [TUPLE_W-1:0]     o_display_data,
    output logic                   o_display_data_valid,
    output logic                   o_display_busy,
    output logic                   o_display_overrun
`ifdef DISPLAY_FETCH_STATS_EN
    ,
    output logic [15:0]            o_stat_rows,
    output logic [15:0]            o_stat_stall
`endif
);

    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_WORDS);

    fetch_state_t           r_state;
    logic [VRAM_ADDR_W-1:0] r_base;
    logic [VRAM_ADDR_W-1:0] r_addr;
    logic                   r_req;
    logic                   r_busy;
    logic                   r_overrun;
    logic [CNT_W-1:0]       r_req_cnt;
    logic [CNT_W-1:0]       r_ret_cnt;
    logic [COLUMN_W-1:0]    r_column;
    logic [TUPLE_W-1:0]     r_data;
    logic                   r_data_valid;

    logic                   w_accept;
    logic                   w_ret_ok;
    logic                   w_ret_drop;
    logic                   w_start_ok;
    logic                   w_can_issue;
    logic                   w_credit_empty;
    logic [CNT_W-1:0]       w_req_cnt_next;

    assign w_accept       = r_req && vram_bus.vram_ack;
    assign w_ret_ok       = vram_bus.vram_rdata_valid && !w_credit_empty;
    assign w_ret_drop     = vram_bus.vram_rdata_valid && w_credit_empty;
    assign w_start_ok     = i_display_start && (r_state == IDLE);
    assign w_req_cnt_next = r_req_cnt + {{(CNT_W-1){1'b0}}, w_accept};

    vram_display_fetch_credit u_credit (
        .i_clk       (i_master_clk),
        .i_rst       (i_reset),
        .i_inc       (w_accept),
        .i_dec       (w_ret_ok),
        .i_limit     (CREDIT_W'(MAX_OUTSTANDING)),
        .o_can_issue (w_can_issue),
        .o_empty     (w_credit_empty)
    );

    // Request FSM: issues addresses, holds them until accepted, tracks busy/overrun.
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_base    <= {VRAM_ADDR_W{1'b0}};
            r_addr    <= {VRAM_ADDR_W{1'b0}};
            r_req     <= 1'b0;
            r_req_cnt <= {CNT_W{1'b0}};
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Late start or a return nobody asked for both flag an overrun.
            if ((i_display_start && r_busy) || w_ret_drop) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_display_start) begin
                        r_state   <= FETCH;
                        r_base    <= i_display_address;
                        r_addr    <= i_display_address;
                        r_req_cnt <= {CNT_W{1'b0}};
                        r_req     <= w_can_issue;
                        r_busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    // A pending request stays frozen until the arbiter takes it.
                    if (!(r_req && !vram_bus.vram_ack)) begin
                        r_req_cnt <= w_req_cnt_next;
                        r_addr    <= row_addr(r_base, w_req_cnt_next);
                        if (w_req_cnt_next == ROW_LAST) begin
                            r_req   <= 1'b0;
                            r_state <= DRAIN;
                        end else begin
                            r_req   <= w_can_issue;
                        end
                    end
                end
                DRAIN: begin
                    if (r_ret_cnt == ROW_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Return path: registers each accepted tuple with its column index.
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ret_cnt    <= {CNT_W{1'b0}};
            r_column     <= {COLUMN_W{1'b0}};
            r_data       <= {TUPLE_W{1'b0}};
            r_data_valid <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_ret_cnt <= {CNT_W{1'b0}};
            end else if (w_ret_ok) begin
                r_ret_cnt <= r_ret_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            r_data_valid <= w_ret_ok;
            if (w_ret_ok) begin
                r_column <= r_ret_cnt[COLUMN_W-1:0];
                r_data   <= vram_bus.vram_rdata;
            end
        end
    end

    assign vram_bus.vram_req     = r_req;
    assign vram_bus.vram_address = r_addr;
    assign o_display_column      = r_column;
    assign o_display_data        = r_data;
    assign o_display_data_valid  = r_data_valid;
    assign o_display_busy        = r_busy;
    assign o_display_overrun     = r_overrun;

`ifdef DISPLAY_FETCH_STATS_EN
    logic [15:0] r_stat_rows;
    logic [15:0] r_stat_stall;

    // Completed-row counter (wraps) and stalled-request counter (saturates).
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stat_rows  <= 16'h0000;
            r_stat_stall <= 16'h0000;
        end else begin
            if ((r_state == DRAIN) && (r_ret_cnt == ROW_LAST)) begin
                r_stat_rows <= r_stat_rows + 16'h0001;
            end
            if (r_req && !vram_bus.vram_ack && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'h0001;
            end
        end
    end

    assign o_stat_rows  = r_stat_rows;
    assign o_stat_stall = r_stat_stall;
`endif

endmodule
